// File: rtl/qft_pair_sequencer.sv
// rtl/qft_pair_sequencer.sv - steps a 2^NQ amplitude bank through one single-qubit gate pass
// Visits each (a, a|2^t) pair in ascending a: issue operands, await result, pulse two write enables.
module qft_pair_sequencer #(
  parameter int NQ     = 3,
  parameter int ADDR_W = NQ,
  parameter int TGT_W  = $clog2(NQ) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TGT_W-1:0]      target,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     rd_addr_a,
  output logic [ADDR_W-1:0]     rd_addr_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  input  logic                  res_valid,
  output logic [(1<<NQ)-1:0]    wr_en
);

  localparam int N   = 1 << NQ;
  localparam int K_W = ADDR_W - 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N / 2 - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, FIN} state_t;

  state_t             state, state_n;
  logic [K_W-1:0]     k, k_n;
  logic [TGT_W-1:0]   tgt, tgt_n;
  logic               range_err, range_err_n;
  logic [ADDR_W-1:0]  addr_a, addr_b, addr_a_n, addr_b_n;

  // Pair index k becomes address a by inserting a zero at bit position t.
  function automatic logic [ADDR_W-1:0] pair_base(input logic [K_W-1:0] kk,
                                                  input logic [TGT_W-1:0] t);
    logic [ADDR_W-1:0] ke;
    logic [ADDR_W-1:0] low;
    ke  = ADDR_W'(kk);
    low = (ADDR_W'(1) << t) - ADDR_W'(1);
    return ((ke & ~low) << 1) | (ke & low);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      tgt       <= '0;
      range_err <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      tgt       <= tgt_n;
      range_err <= range_err_n;
      addr_a    <= addr_a_n;
      addr_b    <= addr_b_n;
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    tgt_n       = tgt;
    range_err_n = range_err;
    addr_a_n    = addr_a;
    addr_b_n    = addr_b;
    case (state)
      IDLE: begin
        if (start) begin
          tgt_n = target;
          k_n   = '0;
          if (target >= TGT_W'(NQ)) begin
            range_err_n = 1'b1;
            state_n     = FIN;
          end else begin
            range_err_n = 1'b0;
            addr_a_n    = pair_base('0, target);
            addr_b_n    = pair_base('0, target) | (ADDR_W'(1) << target);
            state_n     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_ready) state_n = WAIT;
      end
      WAIT: begin
        if (res_valid) state_n = WRITE;
      end
      WRITE: begin
        if (k == K_LAST) begin
          state_n = FIN;
        end else begin
          k_n      = k + K_W'(1);
          addr_a_n = pair_base(k + K_W'(1), tgt);
          addr_b_n = pair_base(k + K_W'(1), tgt) | (ADDR_W'(1) << tgt);
          state_n  = ISSUE;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    err       = (state == FIN) && range_err;
    op_valid  = (state == ISSUE);
    rd_addr_a = addr_a;
    rd_addr_b = addr_b;
    wr_en     = '0;
    if (state == WRITE) begin
      wr_en[addr_a] = 1'b1;
      wr_en[addr_b] = 1'b1;
    end
  end

endmodule

// File: tb/tb_qft_pair_sequencer.sv
// tb/tb_qft_pair_sequencer.sv - scoreboard bench for qft_pair_sequencer
// Expected pair lists come from enumerating addresses with bit t clear; a monitor pops them on wr_en/done.
module tb_qft_pair_sequencer;

  localparam int NQ    = 3;
  localparam int N     = 1 << NQ;
  localparam int TGT_W = $clog2(NQ) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [TGT_W-1:0]  target;
  logic              busy, done, err, op_valid;
  logic              op_ready, res_valid;
  logic [NQ-1:0]     rd_addr_a, rd_addr_b;
  logic [N-1:0]      wr_en;

  qft_pair_sequencer #(.NQ(NQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .target    (target),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .wr_en     (wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           a;
    int           b;
    logic [N-1:0] we;
  } pair_t;

  pair_t exp_pairs[$];
  bit    exp_err[$];
  int    vectors     = 0;
  int    miscompares = 0;

  int    ready_mode  = 0;
  int    res_delay   = 0;
  bit    noise_en    = 1'b0;
  int    stall_left  = 0;
  int    writes_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: every address with bit t clear, ascending, pairs with its partner a + 2^t.
  task automatic expect_pass(input int t);
    pair_t p;
    if (t >= NQ) begin
      exp_err.push_back(1'b1);
      return;
    end
    for (int a = 0; a < N; a++) begin
      if (((a >> t) & 1) == 0) begin
        p.a  = a;
        p.b  = a + (1 << t);
        p.we = (N'(1) << p.a) | (N'(1) << p.b);
        exp_pairs.push_back(p);
      end
    end
    exp_err.push_back(1'b0);
  endtask

  // Datapath model: random or fixed readiness, result a set delay after acceptance,
  // optional stray res_valid pulses whenever no result is owed.
  logic acc_edge;
  always @(posedge clk or posedge rst) begin
    if (rst) acc_edge <= 1'b0;
    else     acc_edge <= op_valid & op_ready;
  end

  initial begin
    int wait_cnt;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    wait_cnt  = -1;
    forever begin
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      if (rst) begin
        wait_cnt = -1;
        op_ready = 1'b0;
      end else begin
        if (acc_edge) wait_cnt = (res_delay < 0) ? int'($urandom_range(0, 3)) : res_delay;
        if (wait_cnt == 0) begin
          res_valid = 1'b1;
          wait_cnt  = -1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end else if (noise_en) begin
          res_valid = ($urandom_range(0, 2) == 0);
        end
        if (stall_left > 0 && op_valid) begin
          op_ready = 1'b0;
          stall_left--;
        end else begin
          op_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
      end
    end
  end

  pair_t         mon_p;
  bit            mon_e;
  bit            hold_pending = 1'b0;
  logic [NQ-1:0] hold_a, hold_b;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_op_valid", op_valid, 1);
        check("hold_addr_a", rd_addr_a, hold_a);
        check("hold_addr_b", rd_addr_b, hold_b);
      end
      hold_pending = op_valid && !op_ready;
      hold_a       = rd_addr_a;
      hold_b       = rd_addr_b;
      if (wr_en != '0) begin
        writes_seen++;
        if (exp_pairs.size() == 0) begin
          check("wr_en_unexpected", wr_en, 0);
        end else begin
          mon_p = exp_pairs.pop_front();
          check("wr_en", wr_en, mon_p.we);
          check("pair_a", rd_addr_a, mon_p.a);
          check("pair_b", rd_addr_b, mon_p.b);
        end
      end
      if (done) begin
        if (exp_err.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          mon_e = exp_err.pop_front();
          check("err", err, mon_e);
          check("pairs_left_at_done", exp_pairs.size(), 0);
        end
      end else if (err) begin
        check("err_without_done", err, 0);
      end
    end
  end

  task automatic run_pass(input int t, input int want_cycles, input bit spurious_start);
    int cyc;
    bit seen_done;
    expect_pass(t);
    @(negedge clk);
    target = TGT_W'(t);
    start  = 1'b1;
    cyc       = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      check("busy_in_pass", busy, 1);
      if (t >= NQ) check("no_op_valid_on_err", op_valid, 0);
      seen_done = done;
      start  = spurious_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      target = TGT_W'($urandom_range(0, (1 << TGT_W) - 1));
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done after %0d cycles, expected done", cyc);
    end else if (want_cycles > 0) begin
      check("done_cycle", cyc, want_cycles);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_fin", busy, 0);
    @(negedge clk);
    check("no_restart_from_fin", busy, 0);
  endtask

  task automatic reset_mid_wait_test();
    int w0;
    bit found;
    ready_mode = 0;
    res_delay  = 4;
    noise_en   = 1'b0;
    found      = 1'b0;
    expect_pass(1);
    @(negedge clk);
    w0     = writes_seen;
    target = TGT_W'(1);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (writes_seen == w0 + 1 && busy && !op_valid && wr_en == '0 && !done) found = 1'b1;
    end
    check("reached_second_wait", found, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr_a", rd_addr_a, 0);
    check("rst_addr_b", rd_addr_b, 0);
    exp_pairs.delete();
    exp_err.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", busy, 0);
    res_delay = 0;
  endtask

  initial begin
    int t;
    int want;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_op_valid", op_valid, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_addr_a", rd_addr_a, 0);
    check("reset_addr_b", rd_addr_b, 0);
    rst = 1'b0;
    @(negedge clk);

    ready_mode = 0;
    res_delay  = 0;
    noise_en   = 1'b0;
    run_pass(1, 3 * (N / 2) + 1, 1'b0);
    run_pass(0, 3 * (N / 2) + 1, 1'b0);
    run_pass(2, 3 * (N / 2) + 1, 1'b0);
    run_pass(3, 1, 1'b0);

    noise_en   = 1'b1;
    stall_left = 5;
    run_pass(2, 0, 1'b1);
    noise_en   = 1'b0;

    reset_mid_wait_test();
    run_pass(1, 3 * (N / 2) + 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      t          = int'($urandom_range(0, (1 << TGT_W) - 1));
      ready_mode = int'($urandom_range(0, 1));
      res_delay  = ($urandom_range(0, 1) == 0) ? 0 : -1;
      noise_en   = ($urandom_range(0, 1) == 1);
      stall_left = (ready_mode == 1) ? int'($urandom_range(0, 3)) : 0;
      want       = (ready_mode == 0 && res_delay == 0) ? ((t < NQ) ? 3 * (N / 2) + 1 : 1) : 0;
      run_pass(t, want, ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_pairs.size() + exp_err.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
